// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: 4-requester round-robin arbiter that drives a registered 2-bit
//   grant code into a downstream MSB-first 2-to-4 select decoder (code 00 -> sel[3]).
// Latency: 1 cycle from req to grant_valid. Back-to-back grants have no idle bubble.
// Backpressure: none. The owner holds the grant until it drops req, pulses
//   grant_release, or reaches HOLD_MAX cycles.
// Ports: clk, rst_n (async active-low), req[3:0], grant_release (the owner gives up
//   the grant this cycle), grant_code[1:0], grant_valid, hold_cnt[CNT_W-1:0].
// Optional build macro RR_GRANT_STATS_EN adds grant_total[15:0] (wrapping count of
//   grants issued) and timeout_total[7:0] (saturating count of timeout-only ends).
module rr_grant_encoder #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic             grant_release,
  output logic [1:0]       grant_code,
  output logic             grant_valid,
  output logic [CNT_W-1:0] hold_cnt
`ifdef RR_GRANT_STATS_EN
  ,
  output logic [15:0]      grant_total,
  output logic [7:0]       timeout_total
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       grant_code_q, grant_code_d;
  logic             grant_valid_q, grant_valid_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  // Returns {found, index}. The loop runs from the lowest priority upward, so the
  // last hit written is the requester closest to ptr in the search order.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic       end_drop, end_rel, end_tmo, grant_end;
  logic [1:0] owner_nxt;
  logic [3:0] arb_req;
  logic [2:0] pick;
  logic       new_grant;

  always_comb begin
    end_drop  = !req[grant_code_q];
    end_rel   = grant_release;
    end_tmo   = (hold_cnt_q == HOLD_LIM);
    grant_end = (state_q == GRANT) && (end_drop || end_rel || end_tmo);
    owner_nxt = grant_code_q + 2'd1;

    // A released or timed-out owner sits out the arbitration at its own end edge.
    arb_req = req;
    if ((state_q == GRANT) && (end_rel || end_tmo)) arb_req[grant_code_q] = 1'b0;

    pick = rr_pick(arb_req, (state_q == GRANT) ? owner_nxt : ptr_q);

    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_code_d  = grant_code_q;
    grant_valid_d = grant_valid_q;
    hold_cnt_d    = hold_cnt_q;
    new_grant     = 1'b0;

    if (state_q == IDLE) begin
      if (pick[2]) begin
        new_grant     = 1'b1;
        state_d       = GRANT;
        grant_code_d  = pick[1:0];
        grant_valid_d = 1'b1;
        hold_cnt_d    = CNT_W'(1);
      end else begin
        grant_valid_d = 1'b0;
        hold_cnt_d    = '0;
      end
    end else if (grant_end) begin
      ptr_d = owner_nxt;
      if (pick[2]) begin
        new_grant     = 1'b1;
        grant_code_d  = pick[1:0];
        grant_valid_d = 1'b1;
        hold_cnt_d    = CNT_W'(1);
      end else begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
        hold_cnt_d    = '0;
      end
    end else if (hold_cnt_q != HOLD_LIM) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= 2'd0;
      grant_code_q  <= 2'b00;
      grant_valid_q <= 1'b0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_code_q  <= grant_code_d;
      grant_valid_q <= grant_valid_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign grant_code  = grant_code_q;
  assign grant_valid = grant_valid_q;
  assign hold_cnt    = hold_cnt_q;

`ifdef RR_GRANT_STATS_EN
  logic [15:0] grant_total_q, grant_total_d;
  logic [7:0]  timeout_total_q, timeout_total_d;

  always_comb begin
    grant_total_d   = grant_total_q + 16'(new_grant);
    timeout_total_d = timeout_total_q;
    // Only ends where the timeout is the sole cause are counted.
    if (grant_end && end_tmo && !end_drop && !end_rel && (timeout_total_q != 8'hFF))
      timeout_total_d = timeout_total_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_total_q   <= '0;
      timeout_total_q <= '0;
    end else begin
      grant_total_q   <= grant_total_d;
      timeout_total_q <= timeout_total_d;
    end
  end

  assign grant_total   = grant_total_q;
  assign timeout_total = timeout_total_q;
`else
  logic unused_new_grant;
  assign unused_new_grant = new_grant;
`endif

endmodule

// File: tb/tb_rr_grant_encoder.sv
// tb_rr_grant_encoder: directed checks of rr_grant_encoder. Three instances share
//   the stimulus with HOLD_MAX = 15, 3 and 2 so each timeout scenario has a matching
//   DUT; each scenario checks only the instance it targets.
module tb_rr_grant_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       grant_release;

  logic [1:0] code15, code3, code2;
  logic       vld15, vld3, vld2;
  logic [7:0] cnt15, cnt3, cnt2;
`ifdef RR_GRANT_STATS_EN
  logic [15:0] gt15, gt3, gt2;
  logic [7:0]  tt15, tt3, tt2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_grant_encoder #(.HOLD_MAX(15), .CNT_W(8)) dut15 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant_release(grant_release),
    .grant_code(code15), .grant_valid(vld15), .hold_cnt(cnt15)
`ifdef RR_GRANT_STATS_EN
    , .grant_total(gt15), .timeout_total(tt15)
`endif
  );

  rr_grant_encoder #(.HOLD_MAX(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant_release(grant_release),
    .grant_code(code3), .grant_valid(vld3), .hold_cnt(cnt3)
`ifdef RR_GRANT_STATS_EN
    , .grant_total(gt3), .timeout_total(tt3)
`endif
  );

  rr_grant_encoder #(.HOLD_MAX(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant_release(grant_release),
    .grant_code(code2), .grant_valid(vld2), .hold_cnt(cnt2)
`ifdef RR_GRANT_STATS_EN
    , .grant_total(gt2), .timeout_total(tt2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges; ends 3 time units after a sample point.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  logic [1:0] exp_code3 [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
  logic [7:0] exp_cnt3  [7] = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd1};
  logic [3:0] sel;

  initial begin
    rst_n = 1'b0;
    req = 4'b0000;
    grant_release = 1'b0;

    // Reset state
    #3;
    chk("rst_code", 32'(code15), 32'h0);
    chk("rst_vld", 32'(vld15), 32'h0);
    chk("rst_cnt", 32'(cnt15), 32'h0);
    #4;
    rst_n = 1'b1;

    // Single requester 2: granted after one edge, decoder select 0010
    req = 4'b0100;
    step();
    chk("t1_vld", 32'(vld15), 32'h1);
    chk("t1_code", 32'(code15), 32'h2);
    chk("t1_cnt", 32'(cnt15), 32'h1);
    sel = 4'b1000 >> code15;
    chk("t1_sel", 32'(sel), 32'h2);

    // All requesting with release every cycle: pure rotation, no bubbles
    do_reset();
    req = 4'b1111;
    grant_release = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t2_code%0d", i), 32'(code15), 32'(i % 4));
      chk($sformatf("t2_vld%0d", i), 32'(vld15), 32'h1);
    end
`ifdef RR_GRANT_STATS_EN
    chk("t2_gtotal", 32'(gt15), 32'd5);
`endif
    grant_release = 1'b0;

    // HOLD_MAX=3, req 0011: timeout-driven alternation between 0 and 1
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("t3_code%0d", i), 32'(code3), 32'(exp_code3[i]));
      chk($sformatf("t3_cnt%0d", i), 32'(cnt3), 32'(exp_cnt3[i]));
      chk($sformatf("t3_vld%0d", i), 32'(vld3), 32'h1);
    end
`ifdef RR_GRANT_STATS_EN
    chk("t3_ttotal", 32'(tt3), 32'd2);
`endif

    // Owner 1 drops req and releases at the same edge; only requester 3 wants it
    do_reset();
    req = 4'b0010;
    step();
    chk("t4_code_own", 32'(code15), 32'h1);
    step();
    chk("t4_hold", 32'(cnt15), 32'h2);
    req = 4'b1000;
    grant_release = 1'b1;
    step();
    grant_release = 1'b0;
    chk("t4_code_new", 32'(code15), 32'h3);
    chk("t4_vld_new", 32'(vld15), 32'h1);
    chk("t4_cnt_new", 32'(cnt15), 32'h1);

    // HOLD_MAX=2, sole requester 0: two cycles, one idle cycle, regrant
    do_reset();
    req = 4'b0001;
    step();
    chk("t5_vld_a", 32'(vld2), 32'h1);
    chk("t5_cnt_a", 32'(cnt2), 32'h1);
    step();
    chk("t5_cnt_b", 32'(cnt2), 32'h2);
    step();
    chk("t5_vld_idle", 32'(vld2), 32'h0);
    chk("t5_cnt_idle", 32'(cnt2), 32'h0);
    chk("t5_code_idle", 32'(code2), 32'h0);
    step();
    chk("t5_vld_re", 32'(vld2), 32'h1);
    chk("t5_code_re", 32'(code2), 32'h0);
    chk("t5_cnt_re", 32'(cnt2), 32'h1);

    // Asynchronous reset in the middle of a grant (code 3, hold 5)
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 5; i++) step();
    chk("t6_pre_code", 32'(code15), 32'h3);
    chk("t6_pre_cnt", 32'(cnt15), 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_code", 32'(code15), 32'h0);
    chk("t6_vld", 32'(vld15), 32'h0);
    chk("t6_cnt", 32'(cnt15), 32'h0);
`ifdef RR_GRANT_STATS_EN
    chk("t6_gtotal", 32'(gt15), 32'h0);
    chk("t6_ttotal", 32'(tt15), 32'h0);
`endif
    #2;
    rst_n = 1'b1;
    req = 4'b0000;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
